// File: rtl/load_store_unit.sv
// Purpose : memory stage for LOAD/STORE; runs one req/ack data-memory transaction at a time.
// Latency : start -> done = 2 cycles + ack wait cycles; decode fault 1 cycle after start.
// Backpr. : core stalls while busy=1; start is ignored (not queued) until IDLE.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, is_store, funct3   launch a transaction (sampled only in IDLE)
//   addr, store_data          effective address from ALU, rs2 value
//   busy, done, fault         status; done/fault are one-cycle pulses
//   load_data                 extended load result, valid with done, held until next done
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ack   data-memory bus
//
// Build option: define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word accesses;
// when undefined the low address bits below the access size are ignored.

module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255  // 0 disables the ack timeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  lsb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] load_data_q;

  logic        latch_en;
  logic        capture_en;

  // ---------------------------------------------------------------------------
  // Request decode (from the live inputs, used only when start is taken in IDLE)
  // ---------------------------------------------------------------------------
  logic        f3_legal;
  logic        misalign;
  logic        dec_ok;
  logic [3:0]  strb_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    f3_legal = 1'b0;
    if (is_store) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] encodes the access size for both loads and stores (00 B, 01 H, 10 W).
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign dec_ok = f3_legal && !misalign;

  // Store data is replicated across every lane so the strobes alone pick the bytes.
  always_comb begin
    strb_calc  = 4'b1111;
    wdata_calc = store_data;
    case (funct3[1:0])
      2'b00: begin
        strb_calc  = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_calc  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data[15:0]}};
      end
      default: begin
        strb_calc  = 4'b1111;
        wdata_calc = store_data;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returning bus word, using the latched request
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  assign rd_byte = mem_rdata[{lsb_q, 3'b000} +: 8];
  assign rd_half = mem_rdata[{lsb_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = mem_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h000000, rd_byte};
      3'b101:  ld_ext = {16'h0000, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dec_ok) begin
            state_d  = S_REQ;
            latch_en = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d    = S_RESP;
          capture_en = !store_q;
          cnt_d      = '0;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q + CW'(1) == TO_VAL)) begin
          // Giving up here drops mem_req; any later ack arrives in IDLE and is ignored.
          state_d = S_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      lsb_q       <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        store_q <= is_store;
        f3_q    <= funct3;
        lsb_q   <= addr[1:0];
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wdata_calc;
        wstrb_q <= is_store ? strb_calc : 4'b0000;
      end
      // Captured on the ack edge so the value is already visible in the RESP cycle with done.
      if (capture_en) begin
        load_data_q <= ld_ext;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign fault     = (state_q == S_ERR);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = (state_q == S_REQ) && store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed + random transactions against load_store_unit with a byte-lane model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).

module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  logic [31:0] ld_exp = 32'h0;

  load_store_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---- reference model: accesses described as (size in bytes, offset in word) ----
  function automatic int m_size(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
    int lo;
    lo = int'(a % 32'd4);
    return lo - (lo % m_size(f));
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f, input logic [31:0] a);
    bit ok;
    if (st) ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    else    ok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if (ok && ((a % 32'(m_size(f))) != 32'd0)) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f, input logic [31:0] a);
    return 4'(((1 << m_size(f)) - 1) << m_off(f, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    if (m_size(f) == 1) return (sd & 32'hFF) * 32'h01010101;
    if (m_size(f) == 2) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] mask, val;
    int sz;
    sz = m_size(f);
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    val  = (rd >> (8 * m_off(f, a))) & mask;
    if (f < 3'd4 && val > (mask >> 1)) val = val | ~mask;
    return val;
  endfunction

  // One transaction; dly = REQ cycles before ack (>= TO means no ack, expect timeout).
  task automatic run_txn(input bit st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int dly,
                         input bit poke_start);
    bit ok;
    int nreq;
    ok = m_legal(st, f, a);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (!ok) begin
      chk1("dec_fault", fault, 1'b1);
      chk1("dec_noreq", mem_req, 1'b0);
      chk1("dec_nodone", done, 1'b0);
      @(negedge clk);
      chk1("dec_idle", busy, 1'b0);
      chk32("dec_ld_hold", load_data, ld_exp);
    end else begin
      nreq = (dly < TO) ? dly + 1 : TO;
      for (int i = 0; i < nreq; i++) begin
        chk1("req_hi", mem_req, 1'b1);
        chk1("req_we", mem_we, st);
        chk32("req_addr", mem_addr, {a[31:2], 2'b00});
        chk32("req_strb", 32'(mem_wstrb), st ? 32'(m_strb(f, a)) : 32'h0);
        if (st) chk32("req_wdata", mem_wdata, m_wdata(f, sd));
        chk1("req_nodone", done, 1'b0);
        if (i == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
        if (poke_start && i == 0) start = 1'b1;  // must be ignored while busy
        @(negedge clk);
        mem_ack = 1'b0; start = 1'b0; mem_rdata = $urandom;
      end
      if (dly < TO) begin
        if (!st) ld_exp = m_load(f, a, rd);
        chk1("resp_done", done, 1'b1);
        chk1("resp_nofault", fault, 1'b0);
        chk1("resp_noreq", mem_req, 1'b0);
        chk32("resp_ldata", load_data, ld_exp);
      end else begin
        chk1("to_fault", fault, 1'b1);
        chk1("to_noreq", mem_req, 1'b0);
        chk1("to_nodone", done, 1'b0);
      end
      @(negedge clk);
      chk1("end_idle", busy, 1'b0);
      chk1("end_nodone", done, 1'b0);
      chk32("end_ld_hold", load_data, ld_exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk32("rst_addr", mem_addr, 32'h0);
    chk32("rst_wdata", mem_wdata, 32'h0);
    chk32("rst_strb", 32'(mem_wstrb), 32'h0);
    chk32("rst_ldata", load_data, 32'h0);
    rst = 1'b0;

    // SW with two wait cycles: done lands 4 cycles after start
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b1);
    chk32("t1_addr", mem_addr, 32'h100);
    chk32("t1_strb", 32'(mem_wstrb), 32'hF);
    chk32("t1_wdata", mem_wdata, 32'hDEADBEEF);
    // LB / LBU of top byte
    run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0, 1'b0);
    chk32("t2_lb", load_data, 32'hFFFFFF80);
    run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 0, 1'b0);
    chk32("t2_lbu", load_data, 32'h00000080);
    // SH upper half, LHU upper half
    run_txn(1'b1, 3'b001, 32'h42, 32'h0000ABCD, 32'h0, 1, 1'b0);
    chk32("t3_addr", mem_addr, 32'h40);
    chk32("t3_strb", 32'(mem_wstrb), 32'hC);
    chk32("t3_wdata", mem_wdata, 32'hABCDABCD);
    run_txn(1'b0, 3'b101, 32'h42, 32'h0, 32'h1234_5678, 0, 1'b0);
    chk32("t3_lhu", load_data, 32'h00001234);
    // illegal load funct3
    run_txn(1'b0, 3'b011, 32'h80, 32'h0, 32'h0, 0, 1'b0);
    chk32("t4_ld_hold", load_data, 32'h00001234);
    // timeout, then a late ack two cycles after the fault
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 99, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk1("t5_late_busy", busy, 1'b0);
    chk1("t5_late_done", done, 1'b0);
    chk1("t5_late_fault", fault, 1'b0);
    chk32("t5_late_ldata", load_data, ld_exp);
    // reset during REQ
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h500; store_data = 32'h1111_2222;
    @(negedge clk);
    start = 1'b0;
    chk1("t6_req", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ld_exp = 32'h0;
    chk1("t6_noreq", mem_req, 1'b0);
    chk1("t6_idle", busy, 1'b0);
    chk1("t6_nodone", done, 1'b0);
    @(negedge clk);
    chk1("t6_nodone2", done, 1'b0);
    chk1("t6_nofault", fault, 1'b0);
    chk32("t6_ldata", load_data, 32'h0);
    // misaligned word: trap when enabled, containing word otherwise
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d,
              1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
